// File: rtl/std_round_robin_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until i_done, then priority rotates.
// Optional burst lock: define STD_RR_ARBITER_LOCK_EN to add the i_lock input.

module std_binary_encoder #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_onehot,
    input  logic         i_en,
    output logic [W-1:0] o_idx
);
    always_comb begin
        o_idx = '0;
        if (i_en) begin
            for (int i = 0; i < N; i++) begin
                if (i_onehot[i]) begin
                    o_idx = o_idx | W'(i);
                end
            end
        end
    end
endmodule

module std_round_robin_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_WIDTH = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic                 i_done,
`ifdef STD_RR_ARBITER_LOCK_EN
    input  logic                 i_lock,
`endif
    output logic [N_REQ-1:0]     o_gnt,
    output logic [IDX_WIDTH-1:0] o_gnt_idx,
    output logic                 o_busy
);
    // o_busy is the externally visible copy of the two-state FSM.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] cur_idx;
    logic [IDX_WIDTH-1:0] base;
    logic [IDX_WIDTH-1:0] cand;
    logic [N_REQ-1:0]     sel_oh;
    logic                 sel_found;
    logic                 lock_hold;

`ifdef STD_RR_ARBITER_LOCK_EN
    assign lock_hold = i_lock;
`else
    assign lock_hold = 1'b0;
`endif

    std_binary_encoder #(
        .N (N_REQ),
        .W (IDX_WIDTH)
    ) u_enc (
        .i_onehot (gnt_q),
        .i_en     (state_q == ST_GRANT),
        .o_idx    (cur_idx)
    );

    // On completion the search starts after the finishing holder, which is the new pointer.
    assign base = (state_q == ST_GRANT && i_done) ? cur_idx : ptr_q;

    // Search base+1, base+2, ... wrapping at N_REQ-1; base itself is tried last.
    always_comb begin
        sel_oh    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_WIDTH'((int'(base) + i) % N_REQ);
            if (!sel_found && i_req[cand]) begin
                sel_oh[cand] = 1'b1;
                sel_found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    gnt_d   = sel_oh;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_done && !lock_hold) begin
                    ptr_d = cur_idx;
                    if (sel_found) begin
                        gnt_d = sel_oh;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= IDX_WIDTH'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_idx = cur_idx;
    assign o_busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_std_round_robin_arbiter.sv
// Self-checking bench for std_round_robin_arbiter (N_REQ=4 and N_REQ=3 instances).
// Vector table + hand sequences + randomized run against a reference model.

module tb_std_round_robin_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
`ifdef STD_RR_ARBITER_LOCK_EN
    logic       lock;
`endif

    logic [2:0] req3;
    logic       done3;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       busy3;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {gnt, idx, busy}.
    logic [6:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        string      name;
    } vec_t;
    vec_t vecs[$];

    std_round_robin_arbiter #(.N_REQ(4)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
`ifdef STD_RR_ARBITER_LOCK_EN
        .i_lock    (lock),
`endif
        .o_gnt     (gnt),
        .o_gnt_idx (idx),
        .o_busy    (busy)
    );

    std_round_robin_arbiter #(.N_REQ(3)) dut3 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req3),
        .i_done    (done3),
`ifdef STD_RR_ARBITER_LOCK_EN
        .i_lock    (1'b0),
`endif
        .o_gnt     (gnt3),
        .o_gnt_idx (idx3),
        .o_busy    (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare_out(input string nm);
        logic [6:0] e;
        logic [6:0] a;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = exp_q.pop_front();
        a = {gnt, idx, busy};
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                     nm, a[6:3], a[2:1], a[0], e[6:3], e[2:1], e[0]);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                        input logic [1:0] ei, input logic eb, input string nm);
        req  = r;
        done = d;
        exp_q.push_back({eg, ei, eb});
        @(posedge clk);
        #1;
        compare_out(nm);
    endtask

    task automatic reset_step(input logic [3:0] r, input logic d, input string nm);
        rst_n = 1'b0;
        step(r, d, 4'b0000, 2'd0, 1'b0, nm);
        rst_n = 1'b1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].idx, vecs[i].busy, vecs[i].name);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                                input logic [1:0] i, input logic b, input string nm);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.idx = i; v.busy = b; v.name = nm;
        vecs.push_back(v);
    endfunction

    function automatic int pick(input int base, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (base + i) % 4;
            if (r[2'(k)]) return k;
        end
        return -1;
    endfunction

    task automatic step3(input logic [2:0] r, input logic d, input logic [2:0] eg,
                         input logic [1:0] ei, input string nm);
        req3  = r;
        done3 = d;
        @(posedge clk);
        #1;
        check({nm, "_gnt"}, 32'(gnt3), 32'(eg));
        check({nm, "_idx"}, 32'(idx3), 32'(ei));
        check({nm, "_busy"}, 32'(busy3), 32'(1'b1));
    endtask

    initial begin
        int m_ptr;
        int m_hold;
        logic [3:0] rr;
        logic       dd;
        logic [3:0] eg;

        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        req3  = '0;
        done3 = 1'b0;
`ifdef STD_RR_ARBITER_LOCK_EN
        lock  = 1'b0;
`endif

        // 0..6: rotation with all requesting, then single request from idle
        add(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, "t1_first");
        add(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, "t1_rot1");
        add(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, "t1_rot2");
        add(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, "t1_rot3");
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "t1_wrap");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t1_idle");
        add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "t2_grant");
        // 7..10: release, wrap from holder 3
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t2_release");
        add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, "t3_holder3");
        add(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, "t3_wrap");
        add(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, "t3_next");
        // 11..12: after mid-grant reset the pointer is back at 3
        add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, "t4_ptr_reset");
        add(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, "regrant_same");
        // 13..14: release, then i_done while idle
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "to_idle");
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "idle_done_ignored");

        repeat (2) @(posedge clk);
        #1;
        reset_step(4'b0000, 1'b0, "reset_state");

        run_range(0, 6);
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, "t2_hold");
        end
        run_range(7, 10);
        reset_step(4'b0011, 1'b1, "t4_reset_mid_grant");
        run_range(11, 12);

`ifdef STD_RR_ARBITER_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, "t6_lock_hold");
        end
        lock = 1'b0;
        step(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, "t6_unlock");
`endif
        run_range(13, 14);

        // Non-power-of-two instance never produces index 3
        step3(3'b111, 1'b0, 3'b001, 2'd0, "t5_first");
        step3(3'b111, 1'b1, 3'b010, 2'd1, "t5_rot1");
        step3(3'b111, 1'b1, 3'b100, 2'd2, "t5_rot2");
        step3(3'b111, 1'b1, 3'b001, 2'd0, "t5_wrap");
        step3(3'b111, 1'b1, 3'b010, 2'd1, "t5_rot_again");
        req3  = '0;
        done3 = 1'b0;

        // Randomized traffic against an index-based reference model
        reset_step(4'b0000, 1'b0, "rand_reset");
        m_ptr  = 3;
        m_hold = -1;
        for (int c = 0; c < 300; c++) begin
            rr = 4'($urandom_range(0, 15));
            dd = 1'($urandom_range(0, 1));
            if (m_hold < 0) begin
                m_hold = pick(m_ptr, rr);
            end else if (dd) begin
                m_ptr  = m_hold;
                m_hold = pick(m_ptr, rr);
            end
            eg = (m_hold < 0) ? 4'b0000 : 4'(1 << m_hold);
            step(rr, dd, eg, (m_hold < 0) ? 2'd0 : 2'(m_hold), (m_hold >= 0), "rand");
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
